// File: rtl/shifter_pkg.sv
// Shared types and elaboration-time helpers for the pipelined barrel shifter.
// Optional feature macro used by the design: SHIFTER_ROTATE_EN.
package shifter_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

   // Number of binary shift stages (and used shift-amount bits) for a width.
   function automatic int shamt_w(input int xlen);
      return $clog2(xlen);
   endfunction

   // Count of stages held by register groups 0..g; earliest groups take the remainder.
   function automatic int group_end(input int g, input int nstg, input int ngrp);
      int base;
      int extra;
      base  = nstg / ngrp;
      extra = nstg % ngrp;
      return (g + 1) * base + (((g + 1) < extra) ? (g + 1) : extra);
   endfunction

   // First stage index belonging to register group g.
   function automatic int group_first(input int g, input int nstg, input int ngrp);
      return (g == 0) ? 0 : group_end(g - 1, nstg, ngrp);
   endfunction

   // Register group that owns binary stage k.
   function automatic int stage_group(input int k, input int nstg, input int ngrp);
      int r;
      r = ngrp - 1;
      for (int g = ngrp - 1; g >= 0; g--) begin
         if (k < group_end(g, nstg, ngrp)) r = g;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One binary stage of the barrel shifter: right shift by DIST when enabled.
// With SHIFTER_ROTATE_EN defined, the shifted-out bits can be fed back into
// the MSB side (rotate); otherwise the vacated bits always take the fill bit.
module shift_stage #(
   parameter int XLEN = 32,
   parameter int DIST = 1
) (
   input  logic [XLEN-1:0] data,
   input  logic            enable,
   input  logic            fill,
   input  logic            rotate,
   output logic [XLEN-1:0] shifted
);

   logic [DIST-1:0] top_bits;

`ifdef SHIFTER_ROTATE_EN
   assign top_bits = rotate ? data[DIST-1:0] : {DIST{fill}};
`else
   logic unused_rotate;
   assign unused_rotate = rotate;
   assign top_bits      = {DIST{fill}};
`endif

   assign shifted = enable ? {top_bits, data[XLEN-1:DIST]} : data;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA barrel shifter with valid/ready handshake and flush.
// The log2(XLEN) binary stages are spread over PIPE_STAGES register groups.
// SLL is done as reverse -> logical right shift -> reverse.
// Optional macro SHIFTER_ROTATE_EN turns op 11 into ROR; otherwise op 11 is SRL.
import shifter_pkg::*;

module pipelined_shifter #(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       op_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  rs2_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  rd_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam int SW = shamt_w(XLEN);

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) r[i] = d[XLEN-1-i];
      return r;
   endfunction

   // Per-group register contents (index g = register after group g)
   logic [XLEN-1:0]        data_p  [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_p   [PIPE_STAGES];
   logic [SW-1:0]          shamt_p [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] fill_p, rot_p, rev_p, vld_p, rdy;

   logic [XLEN-1:0] chain_in  [SW];
   logic [XLEN-1:0] chain_out [SW];

   shift_op_e       op;
   logic            in_rev, in_fill, in_rot;
   logic [XLEN-1:0] in_data;
   logic [SW-1:0]   in_shamt;

   assign op = shift_op_e'(op_i);

   // Decode the operation into reverse/fill/rotate controls for the stages.
   always_comb begin
      in_rev   = (op == OP_SLL);
      in_fill  = (op == OP_SRA) & rs1_i[XLEN-1];
`ifdef SHIFTER_ROTATE_EN
      in_rot   = (op == OP_ROR);
`else
      in_rot   = 1'b0;
`endif
      in_data  = in_rev ? bit_rev(rs1_i) : rs1_i;
      in_shamt = rs2_i[SW-1:0];
   end

   // Upper shift-amount bits are ignored (RV32 semantics); the last group's
   // shift controls are carried but have no later consumer.
   logic unused_bits;
   assign unused_bits = ^{rs2_i[XLEN-1:SW], shamt_p[PIPE_STAGES-1],
                          fill_p[PIPE_STAGES-1], rot_p[PIPE_STAGES-1],
                          rev_p[PIPE_STAGES-1]};

   // Flush squashes everything, so the input is always consumed during it.
   assign in_ready_o  = flush_i | rdy[0];
   assign out_valid_o = vld_p[PIPE_STAGES-1];
   assign rd_o        = data_p[PIPE_STAGES-1];
   assign tag_o       = tag_p[PIPE_STAGES-1];

   for (genvar k = 0; k < SW; k++) begin : g_stage
      localparam int G = stage_group(k, SW, PIPE_STAGES);
      localparam int F = group_first(G, SW, PIPE_STAGES);
      logic en_k, fill_k, rot_k;
      if (G == 0) begin : g_front
         if (k == 0) begin : g_head
            assign chain_in[k] = in_data;
         end else begin : g_link
            assign chain_in[k] = chain_out[k-1];
         end
         assign en_k   = in_shamt[k];
         assign fill_k = in_fill;
         assign rot_k  = in_rot;
      end else begin : g_back
         if (k == F) begin : g_head
            assign chain_in[k] = data_p[G-1];
         end else begin : g_link
            assign chain_in[k] = chain_out[k-1];
         end
         assign en_k   = shamt_p[G-1][k];
         assign fill_k = fill_p[G-1];
         assign rot_k  = rot_p[G-1];
      end
      shift_stage #(.XLEN(XLEN), .DIST(1 << k)) u_stage (
         .data    (chain_in[k]),
         .enable  (en_k),
         .fill    (fill_k),
         .rotate  (rot_k),
         .shifted (chain_out[k])
      );
   end

   for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_group
      localparam int LAST = group_end(g, SW, PIPE_STAGES) - 1;
      logic             src_vld, src_fill, src_rot, src_rev;
      logic [TAG_W-1:0] src_tag;
      logic [SW-1:0]    src_shamt;
      logic [XLEN-1:0]  grp_out;
      logic             vld_q, fill_q, rot_q, rev_q;
      logic [XLEN-1:0]  data_q;
      logic [TAG_W-1:0] tag_q;
      logic [SW-1:0]    shamt_q;

      if (g == 0) begin : g_src_in
         assign src_vld   = in_valid_i;
         assign src_tag   = tag_i;
         assign src_shamt = in_shamt;
         assign src_fill  = in_fill;
         assign src_rot   = in_rot;
         assign src_rev   = in_rev;
      end else begin : g_src_reg
         assign src_vld   = vld_p[g-1];
         assign src_tag   = tag_p[g-1];
         assign src_shamt = shamt_p[g-1];
         assign src_fill  = fill_p[g-1];
         assign src_rot   = rot_p[g-1];
         assign src_rev   = rev_p[g-1];
      end

      if (g == PIPE_STAGES - 1) begin : g_out
         assign grp_out = src_rev ? bit_rev(chain_out[LAST]) : chain_out[LAST];
      end else begin : g_mid
         assign grp_out = chain_out[LAST];
      end

      // A group can take new data unless it and every later group are full.
      assign rdy[g] = out_ready_i | ~(&vld_p[PIPE_STAGES-1:g]);

      // Group register: valid cleared by flush, data moves only on a transfer.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
            rot_q   <= 1'b0;
            rev_q   <= 1'b0;
         end else begin
            if (flush_i)     vld_q <= 1'b0;
            else if (rdy[g]) vld_q <= src_vld;
            if (rdy[g] && src_vld) begin
               data_q  <= grp_out;
               tag_q   <= src_tag;
               shamt_q <= src_shamt;
               fill_q  <= src_fill;
               rot_q   <= src_rot;
               rev_q   <= src_rev;
            end
         end
      end

      assign vld_p[g]   = vld_q;
      assign data_p[g]  = data_q;
      assign tag_p[g]   = tag_q;
      assign shamt_p[g] = shamt_q;
      assign fill_p[g]  = fill_q;
      assign rot_p[g]   = rot_q;
      assign rev_p[g]   = rev_q;
   end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter (XLEN=32, PIPE_STAGES=2).
// Honours SHIFTER_ROTATE_EN when choosing the expected op-11 result.
module tb_pipelined_shifter;

   localparam logic [1:0] SLL = 2'b00;
   localparam logic [1:0] SRL = 2'b01;
   localparam logic [1:0] SRA = 2'b10;
   localparam logic [1:0] ROR = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] rd;
   logic [4:0]  tag_out;

   int n_tests = 0;
   int n_fail  = 0;

   pipelined_shifter #(.XLEN(32), .PIPE_STAGES(2), .TAG_W(5)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .tag_i       (tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .rd_o        (rd),
      .tag_o       (tag_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One isolated op on an empty pipeline with out_ready=1; checks 2-cycle latency.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp);
      @(posedge clk); #1;
      in_valid = 1'b1; op = o; rs1 = a; rs2 = b; tag = t; out_ready = 1'b1;
      #1 check({name, " in_ready"}, 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1 check({name, " early valid"}, 64'(out_valid), 64'(0));
      @(posedge clk); #2;
      check({name, " valid"}, 64'(out_valid), 64'(1));
      check({name, " rd"}, 64'(rd), 64'(exp));
      check({name, " tag"}, 64'(tag_out), 64'(t));
   endtask

   logic [31:0] bp_exp [4] = '{32'h0000_0080, 32'h0000_0040, 32'h0000_0020, 32'h0000_0010};
   logic [31:0] ror_exp;

   initial begin
      int idx;
      int got;
      logic acc;
`ifdef SHIFTER_ROTATE_EN
      ror_exp = 32'h1000_000F;
`else
      ror_exp = 32'h0000_000F;
`endif
      // Reset state
      #3;
      check("rst out_valid", 64'(out_valid), 64'(0));
      check("rst rd", 64'(rd), 64'(0));
      check("rst tag", 64'(tag_out), 64'(0));
      @(posedge clk); @(posedge clk); #3 rst = 1'b0;
      #1 check("post-rst in_ready", 64'(in_ready), 64'(1));

      // Basic function and boundaries
      run_op("sra", SRA, 32'h8000_00F0, 32'd4, 5'h0A, 32'hF800_000F);
      run_op("sll wrap", SLL, 32'h0000_0001, 32'd33, 5'h01, 32'h0000_0002);
      run_op("srl 31", SRL, 32'h8000_0000, 32'd31, 5'h02, 32'h0000_0001);
      run_op("shamt0", SRA, 32'hA5A5_1234, 32'd0, 5'h03, 32'hA5A5_1234);
      run_op("sll 31", SLL, 32'h0000_0003, 32'd31, 5'h04, 32'h8000_0000);
      run_op("sra pos", SRA, 32'h7000_0000, 32'd28, 5'h05, 32'h0000_0007);
      run_op("op11", ROR, 32'h0000_00F1, 32'd4, 5'h06, ror_exp);

      // Back-pressure: 4 ops, out_ready held low for 5 cycles
      @(posedge clk); #1;
      out_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         in_valid = 1'b1; op = SRL; rs1 = 32'h0000_0100;
         rs2 = 32'(idx + 1); tag = 5'(idx + 1);
         #1;
         acc = in_ready;
         if (cyc >= 2) begin
            check("bp in_ready low", 64'(in_ready), 64'(0));
            check("bp rd stable", 64'(rd), 64'(32'h0000_0080));
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      check("bp accepted", 64'(idx), 64'(2));
      check("bp out_valid held", 64'(out_valid), 64'(1));
      check("bp tag held", 64'(tag_out), 64'(1));
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
         in_valid = (idx < 4); op = SRL; rs1 = 32'h0000_0100;
         rs2 = 32'(idx + 1); tag = 5'(idx + 1);
         #1;
         if (out_valid) begin
            check("bp drain rd", 64'(rd), 64'(bp_exp[got]));
            check("bp drain tag", 64'(tag_out), 64'(got + 1));
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      check("bp drained count", 64'(got), 64'(4));
      check("bp issued count", 64'(idx), 64'(4));
      #1 check("bp no duplicate", 64'(out_valid), 64'(0));

      // Flush: two in flight, third presented with flush
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; op = SRL; rs1 = 32'hFFFF_0000; rs2 = 32'd1; tag = 5'h11;
      @(posedge clk); #1;
      rs2 = 32'd2; tag = 5'h12;
      @(posedge clk); #1;
      rs2 = 32'd3; tag = 5'h13; flush = 1'b1;
      #1 check("flush in_ready forced", 64'(in_ready), 64'(1));
      check("flush pre out_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1 check("flush out_valid", 64'(out_valid), 64'(0));
      acc = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(posedge clk); #2;
         acc = acc | out_valid;
      end
      check("flush discarded", 64'(acc), 64'(0));
      run_op("after flush", SRA, 32'h8000_0000, 32'd1, 5'h14, 32'hC000_0000);

      // Reset mid-stream
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; op = SRL; rs1 = 32'hDEAD_BEEF; rs2 = 32'd0; tag = 5'h15;
      @(posedge clk); #1;
      tag = 5'h16;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1 check("mid pre valid", 64'(out_valid), 64'(1));
      #1 rst = 1'b1;
      #1;
      check("mid rst out_valid", 64'(out_valid), 64'(0));
      check("mid rst rd", 64'(rd), 64'(0));
      check("mid rst tag", 64'(tag_out), 64'(0));
      @(posedge clk); #3 rst = 1'b0;
      #1 check("mid post in_ready", 64'(in_ready), 64'(1));
      check("mid post out_valid", 64'(out_valid), 64'(0));
      run_op("after rst", SRL, 32'h0000_F000, 32'd12, 5'h17, 32'h0000_000F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
